// File: rtl/eth_helper_pkg.sv
// Shared definitions for the Ethernet stream taps: AXI response codes,
// stream-type codes and the bit layout of packed B-response records.
package eth_helper_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam logic [2:0] ST_AXI_B  = 3'd0;
  localparam logic [2:0] ST_AXI_AW = 3'd1;
  localparam logic [2:0] ST_AXI_W  = 3'd2;
  localparam logic [2:0] ST_AXI_AR = 3'd3;
  localparam logic [2:0] ST_AXI_R  = 3'd4;

  // B record, LSB first: type | bresp | bid | buser
  function automatic int rec_bresp_lsb(input int type_w);
    return type_w;
  endfunction

  function automatic int rec_bid_lsb(input int type_w);
    return type_w + 2;
  endfunction

  function automatic int rec_buser_lsb(input int type_w, input int id_w);
    return type_w + 2 + id_w;
  endfunction

  function automatic int rec_b_width(input int type_w, input int id_w, input int user_w);
    return type_w + 2 + id_w + user_w;
  endfunction

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage, synchronous active-high reset,
// and full/empty/level status. DEPTH must be a power of two so pointers wrap.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    cnt;
  logic             wr_ok;
  logic             rd_ok;

  assign full  = (cnt == LW'(DEPTH));
  assign empty = (cnt == '0);
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // storage is not reset; the read side gates it with empty
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign level   = cnt;

endmodule

// File: rtl/stream_to_axi_b.sv
// Replays packed B-response records from the inbound stream as AXI B beats.
// Optional STREAM_TO_AXI_B_ERRCNT_EN adds err_count (SLVERR/DECERR handshakes).
module stream_to_axi_b
  import eth_helper_pkg::*;
#(
  parameter int DATA_WIDTH        = 128,
  parameter int ID_WIDTH          = 32,
  parameter int USER_WIDTH        = 64,
  parameter int STREAM_TYPE_WIDTH = 3,
  parameter logic [STREAM_TYPE_WIDTH-1:0] STREAM_TYPE = STREAM_TYPE_WIDTH'(ST_AXI_B),
  parameter int FIFO_DEPTH        = 8,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_WIDTH-1:0]         s_data,
  output logic [ID_WIDTH-1:0]           AXIM_bid,
  output logic [1:0]                    AXIM_bresp,
  output logic [USER_WIDTH-1:0]         AXIM_buser,
  output logic                          AXIM_bvalid,
  input  logic                          AXIM_bready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
`ifdef STREAM_TO_AXI_B_ERRCNT_EN
  output logic [CNT_WIDTH-1:0]          err_count,
`endif
  output logic [CNT_WIDTH-1:0]          drop_count
);

  localparam int BRESP_LSB = rec_bresp_lsb(STREAM_TYPE_WIDTH);
  localparam int BID_LSB   = rec_bid_lsb(STREAM_TYPE_WIDTH);
  localparam int BUSER_LSB = rec_buser_lsb(STREAM_TYPE_WIDTH, ID_WIDTH);
  localparam int REC_END   = rec_b_width(STREAM_TYPE_WIDTH, ID_WIDTH, USER_WIDTH);
  localparam int REC_W     = ID_WIDTH + 2 + USER_WIDTH;
  localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1;

  if (REC_END > DATA_WIDTH) begin : g_bad_layout
    $error("stream_to_axi_b: B record does not fit in DATA_WIDTH");
  end

  if (REC_END < DATA_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^s_data[DATA_WIDTH-1:REC_END];
  end

  logic [STREAM_TYPE_WIDTH-1:0] in_type;
  logic [1:0]                   in_bresp;
  logic [ID_WIDTH-1:0]          in_bid;
  logic [USER_WIDTH-1:0]        in_buser;

  assign in_type  = s_data[STREAM_TYPE_WIDTH-1:0];
  assign in_bresp = s_data[BRESP_LSB +: 2];
  assign in_bid   = s_data[BID_LSB +: ID_WIDTH];
  assign in_buser = s_data[BUSER_LSB +: USER_WIDTH];

  logic             s_ready_q;
  logic             accept;
  logic             push;
  logic             drop;
  logic             pop;
  logic [REC_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic [LVL_W-1:0] level_next;

  assign accept = s_valid && s_ready_q;
  assign push   = accept && (in_type == STREAM_TYPE) && !fifo_full;
  assign drop   = accept && (in_type != STREAM_TYPE);
  assign pop    = AXIM_bvalid && AXIM_bready;

  sync_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (resetn),
    .wr_en   (push),
    .wr_data ({in_bid, in_bresp, in_buser}),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  // s_ready is a flop so it never combinationally follows AXIM_bready
  assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);

  always_ff @(posedge clk) begin
    if (resetn) begin
      s_ready_q  <= 1'b0;
      drop_count <= '0;
    end else begin
      s_ready_q <= (level_next != LVL_W'(FIFO_DEPTH));
      if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
    end
  end

  assign s_ready     = s_ready_q;
  assign level       = fifo_level;
  assign AXIM_bvalid = !fifo_empty;
  assign AXIM_bid    = fifo_empty ? '0 : head[REC_W-1 -: ID_WIDTH];
  assign AXIM_bresp  = fifo_empty ? '0 : head[USER_WIDTH +: 2];
  assign AXIM_buser  = fifo_empty ? '0 : head[USER_WIDTH-1:0];

`ifdef STREAM_TO_AXI_B_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (resetn) begin
      err_count <= '0;
    end else if (pop && resp_is_error(AXIM_bresp) && err_count != '1) begin
      err_count <= err_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_to_axi_b.sv
// Bench for stream_to_axi_b: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_stream_to_axi_b;

  logic         clk;
  logic         resetn;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] s_data;
  logic [31:0]  bid;
  logic [1:0]   bresp;
  logic [63:0]  buser;
  logic         bvalid;
  logic         bready;
  logic [3:0]   level;
  logic [15:0]  drop_count;
`ifdef STREAM_TO_AXI_B_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  int checks = 0;
  int failures = 0;

  stream_to_axi_b dut (
    .clk         (clk),
    .resetn      (resetn),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .AXIM_bid    (bid),
    .AXIM_bresp  (bresp),
    .AXIM_buser  (buser),
    .AXIM_bvalid (bvalid),
    .AXIM_bready (bready),
    .level       (level),
`ifdef STREAM_TO_AXI_B_ERRCNT_EN
    .err_count   (err_count),
`endif
    .drop_count  (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] id;
    logic [1:0]  resp;
    logic [63:0] user;
  } rec_t;

  // Reference model: a bounded queue of 8 records, updated on each rising edge
  rec_t        m_q[$];
  logic        m_ready;
  logic [15:0] m_drops;
  logic [15:0] m_errs;
  bit          m_pop;
  bit          m_acc;

  always @(posedge clk) begin
    if (resetn) begin
      m_q.delete();
      m_ready = 1'b0;
      m_drops = '0;
      m_errs  = '0;
    end else begin
      m_pop = (m_q.size() != 0) && bready;
      m_acc = s_valid && m_ready;
      if (m_pop) begin
        if (m_q[0].resp[1] && m_errs != 16'hFFFF) m_errs = m_errs + 1;
        void'(m_q.pop_front());
      end
      if (m_acc) begin
        if (s_data[2:0] == 3'd0)
          m_q.push_back('{id: s_data[36:5], resp: s_data[4:3], user: s_data[100:37]});
        else if (m_drops != 16'hFFFF)
          m_drops = m_drops + 1;
      end
      m_ready = (m_q.size() != 8);
    end
  end

  function automatic logic [127:0] mk_word(input logic [2:0] t, input logic [1:0] r,
                                           input logic [31:0] id, input logic [63:0] u);
    logic [127:0] w;
    w = {$urandom, $urandom, $urandom, $urandom};
    w[2:0]    = t;
    w[4:3]    = r;
    w[36:5]   = id;
    w[100:37] = u;
    return w;
  endfunction

  task automatic do_reset();
    s_valid = 1'b0;
    bready  = 1'b0;
    resetn  = 1'b1;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn  = 1'b1;
    bready  = 1'b0;
    s_valid = 1'b1;
    s_data  = mk_word(3'd0, 2'b00, 32'h7, 64'h7);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
      checks++;
      if (bvalid !== 1'b0) begin failures++; $display("FAIL reset_bvalid: got %b expected 0", bvalid); end
      checks++;
      if (level !== 4'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", level); end
    end
    resetn  = 1'b0;
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL release_s_ready: got %b expected 1", s_ready); end
    checks++;
    if (bvalid !== 1'b0 || level !== 4'd0) begin
      failures++; $display("FAIL release_empty: got bvalid=%b level=%0d expected 0/0", bvalid, level);
    end
    checks++;
    if (bid !== 32'd0 || bresp !== 2'd0 || buser !== 64'd0 || drop_count !== 16'd0) begin
      failures++;
      $display("FAIL release_zero: got bid=%0h bresp=%0h buser=%0h drops=%0d expected all 0",
               bid, bresp, buser, drop_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    bready  = 1'b1;
    s_valid = 1'b1;
    s_data  = mk_word(3'd0, 2'b00, 32'h5, 64'hAB);
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (bvalid !== 1'b1 || bid !== 32'h5 || bresp !== 2'b00 || buser !== 64'hAB) begin
      failures++;
      $display("FAIL single_beat: got v=%b bid=%0h bresp=%0h buser=%0h expected 1/5/0/ab",
               bvalid, bid, bresp, buser);
    end
    checks++;
    if (level !== 4'd1) begin failures++; $display("FAIL single_level: got %0d expected 1", level); end
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || level !== 4'd0) begin
      failures++; $display("FAIL single_drain: got v=%b level=%0d expected 0/0", bvalid, level);
    end
  endtask

  task automatic test_full();
    do_reset();
    bready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1;
      s_data  = mk_word(3'd0, 2'($urandom_range(0, 3)), 32'(i), {$urandom, $urandom});
      @(negedge clk);
    end
    checks++;
    if (s_ready !== 1'b0 || level !== 4'd8) begin
      failures++; $display("FAIL full_flags: got s_ready=%b level=%0d expected 0/8", s_ready, level);
    end
    s_data = mk_word(3'd0, 2'b00, 32'd9, 64'd9);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (level !== 4'd8 || s_ready !== 1'b0) begin
        failures++; $display("FAIL full_hold: got level=%0d s_ready=%b expected 8/0", level, s_ready);
      end
    end
    s_valid = 1'b0;
    bready  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++;
      if (bvalid !== 1'b1 || bid !== 32'(i)) begin
        failures++; $display("FAIL drain_order: got v=%b bid=%0d expected 1/%0d", bvalid, bid, i);
      end
      if (i == 2) begin
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL ready_after_pop: got %b expected 1", s_ready); end
      end
      @(negedge clk);
    end
    checks++;
    if (bvalid !== 1'b0 || level !== 4'd0) begin
      failures++; $display("FAIL drain_empty: got v=%b level=%0d expected 0/0", bvalid, level);
    end
  endtask

  task automatic test_mismatch();
    logic [2:0]  types [5];
    logic [31:0] want [$];
    int          delivered;
    types = '{3'b010, 3'b000, 3'b010, 3'b000, 3'b010};
    want  = '{32'd101, 32'd103};
    delivered = 0;
    do_reset();
    bready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 5) begin
        s_valid = 1'b1;
        s_data  = mk_word(types[k], 2'b01, 32'(100 + k), 64'(k));
      end else begin
        s_valid = 1'b0;
      end
      @(negedge clk);
      if (bvalid === 1'b1) begin
        checks++;
        if (delivered >= 2 || bid !== want[delivered]) begin
          failures++; $display("FAIL mismatch_bid: got %0d as response %0d", bid, delivered);
        end
        delivered++;
      end
    end
    checks++;
    if (delivered != 2) begin failures++; $display("FAIL mismatch_count: got %0d expected 2", delivered); end
    checks++;
    if (drop_count !== 16'd3) begin failures++; $display("FAIL drop_count: got %0d expected 3", drop_count); end
  endtask

  task automatic test_hold_reset();
    logic [31:0] id;
    logic [1:0]  r;
    logic [63:0] u;
    id = $urandom;
    r  = 2'($urandom_range(0, 3));
    u  = {$urandom, $urandom};
    do_reset();
    bready  = 1'b0;
    s_valid = 1'b1;
    s_data  = mk_word(3'd0, r, id, u);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      s_data = mk_word(3'd0, 2'($urandom_range(0, 3)), $urandom, {$urandom, $urandom});
      checks++;
      if (bvalid !== 1'b1 || bid !== id || bresp !== r || buser !== u) begin
        failures++;
        $display("FAIL hold_stable[%0d]: got v=%b bid=%0h bresp=%0h buser=%0h expected 1/%0h/%0h/%0h",
                 c, bvalid, bid, bresp, buser, id, r, u);
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    bready  = 1'b1;
    resetn  = 1'b1;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0 || level !== 4'd0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got v=%b level=%0d s_ready=%b expected 0/0/0", bvalid, level, s_ready);
    end
    resetn = 1'b0;
    bready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    bready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = mk_word(3'd0, 2'b00, 32'(200 + i), 64'(i));
      @(negedge clk);
      checks++;
      if (bvalid !== 1'b1 || bid !== 32'(200 + i) || level !== 4'd1 || s_ready !== 1'b1) begin
        failures++;
        $display("FAIL back_to_back[%0d]: got v=%b bid=%0d level=%0d s_ready=%b expected 1/%0d/1/1",
                 i, bvalid, bid, level, s_ready, 200 + i);
      end
    end
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b0) begin failures++; $display("FAIL back_to_back_end: got v=%b expected 0", bvalid); end
  endtask

`ifdef STREAM_TO_AXI_B_ERRCNT_EN
  task automatic test_errcnt();
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    do_reset();
    bready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1;
      s_data  = mk_word(3'd0, seq[k], 32'(k), 64'(k));
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (err_count !== 16'd2) begin failures++; $display("FAIL err_count: got %0d expected 2", err_count); end
  endtask
`endif

  task automatic test_random();
    rec_t        exp_head;
    logic        exp_valid;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = mk_word(($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
                        2'($urandom_range(0, 3)), $urandom, {$urandom, $urandom});
      if ((cyc % 64) < 20) bready = ($urandom_range(0, 4) == 0);
      else                 bready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      exp_valid = (m_q.size() != 0);
      exp_head  = exp_valid ? m_q[0] : '{id: '0, resp: '0, user: '0};
      checks++;
      if (s_ready !== m_ready) begin
        failures++; $display("FAIL rand_s_ready@%0d: got %b expected %b", cyc, s_ready, m_ready);
      end
      checks++;
      if (bvalid !== exp_valid || level !== 4'(m_q.size())) begin
        failures++;
        $display("FAIL rand_level@%0d: got v=%b level=%0d expected %b/%0d", cyc, bvalid, level, exp_valid, m_q.size());
      end
      checks++;
      if (bid !== exp_head.id || bresp !== exp_head.resp || buser !== exp_head.user) begin
        failures++;
        $display("FAIL rand_head@%0d: got %0h/%0h/%0h expected %0h/%0h/%0h",
                 cyc, bid, bresp, buser, exp_head.id, exp_head.resp, exp_head.user);
      end
      checks++;
      if (drop_count !== m_drops) begin
        failures++; $display("FAIL rand_drops@%0d: got %0d expected %0d", cyc, drop_count, m_drops);
      end
`ifdef STREAM_TO_AXI_B_ERRCNT_EN
      checks++;
      if (err_count !== m_errs) begin
        failures++; $display("FAIL rand_errs@%0d: got %0d expected %0d", cyc, err_count, m_errs);
      end
`endif
    end
    s_valid = 1'b0;
    bready  = 1'b0;
  endtask

  initial begin
    resetn  = 1'b1;
    s_valid = 1'b0;
    bready  = 1'b0;
    s_data  = '0;
    test_reset();
    test_single();
    test_full();
    test_mismatch();
    test_hold_reset();
    test_back_to_back();
`ifdef STREAM_TO_AXI_B_ERRCNT_EN
    test_errcnt();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
